// File: rtl/cyclotron_dmem_pkg.sv
// Shared width helpers and request record for the Cyclotron dmem serializer.
package cyclotron_dmem_pkg;

    localparam int unsigned DEF_ARCH_LEN       = 32;
    localparam int unsigned DEF_NUM_LANES      = 16;
    localparam int unsigned DEF_DMEM_DATA_BITS = 32;
    localparam int unsigned DEF_DMEM_TAG_BITS  = 32;

    function automatic int unsigned lane_bits(input int unsigned num_lanes);
        return $clog2(num_lanes);
    endfunction

    function automatic int unsigned mem_tag_bits(input int unsigned tag_bits, input int unsigned num_lanes);
        return tag_bits + $clog2(num_lanes);
    endfunction

    function automatic int unsigned size_bits(input int unsigned data_bits);
        return $clog2($clog2(data_bits / 8) + 1);
    endfunction

    function automatic int unsigned mask_bits(input int unsigned data_bits);
        return data_bits / 8;
    endfunction

    // Memory request record at the default tile widths
    typedef struct packed {
        logic                                                      store;
        logic [DEF_ARCH_LEN-1:0]                                   address;
        logic [size_bits(DEF_DMEM_DATA_BITS)-1:0]                  size;
        logic [DEF_DMEM_DATA_BITS-1:0]                             data;
        logic [mask_bits(DEF_DMEM_DATA_BITS)-1:0]                  mask;
        logic [mem_tag_bits(DEF_DMEM_TAG_BITS, DEF_NUM_LANES)-1:0] tag;
    } mem_req_t;

endpackage

// File: rtl/cyclotron_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, with wrap.
module cyclotron_rr_arbiter
    import cyclotron_dmem_pkg::*;
#(
    parameter  int unsigned NUM_LANES = 16,
    localparam int unsigned LANE_BITS = lane_bits(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [LANE_BITS-1:0] ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic [LANE_BITS-1:0] idx,
    output logic                 any
);

    logic [LANE_BITS-1:0] cand;

    // Scan lanes starting at ptr; the index wraps naturally since NUM_LANES is a power of two
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            cand = ptr + LANE_BITS'(i);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cyclotron_dmem_serializer.sv
// Serializes per-lane dmem requests onto one memory port and routes responses
// back by the lane index carried in the upper tag bits.
// Optional macro DMEM_SERIALIZER_PERF_EN adds grant / conflict counters.
module cyclotron_dmem_serializer
    import cyclotron_dmem_pkg::*;
#(
    parameter  int unsigned ARCH_LEN       = 32,
    parameter  int unsigned NUM_LANES      = 16,
    parameter  int unsigned DMEM_DATA_BITS = 32,
    parameter  int unsigned DMEM_TAG_BITS  = 32,
    parameter  int unsigned MAX_INFLIGHT   = 8,
    localparam int unsigned LANE_BITS      = lane_bits(NUM_LANES),
    localparam int unsigned MEM_TAG_BITS   = mem_tag_bits(DMEM_TAG_BITS, NUM_LANES),
    localparam int unsigned DMEM_SIZE_BITS = size_bits(DMEM_DATA_BITS),
    localparam int unsigned DMEM_MASK_BITS = mask_bits(DMEM_DATA_BITS)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_LANES-1:0]                lane_req_valid,
    output logic [NUM_LANES-1:0]                lane_req_ready,
    input  logic [NUM_LANES-1:0]                lane_req_bits_store,
    input  logic [NUM_LANES*DMEM_TAG_BITS-1:0]  lane_req_bits_tag,
    input  logic [NUM_LANES*ARCH_LEN-1:0]       lane_req_bits_address,
    input  logic [NUM_LANES*DMEM_SIZE_BITS-1:0] lane_req_bits_size,
    input  logic [NUM_LANES*DMEM_DATA_BITS-1:0] lane_req_bits_data,
    input  logic [NUM_LANES*DMEM_MASK_BITS-1:0] lane_req_bits_mask,
    output logic [NUM_LANES-1:0]                lane_resp_valid,
    input  logic [NUM_LANES-1:0]                lane_resp_ready,
    output logic [NUM_LANES*DMEM_TAG_BITS-1:0]  lane_resp_bits_tag,
    output logic [NUM_LANES*DMEM_DATA_BITS-1:0] lane_resp_bits_data,
    output logic                                mem_req_valid,
    input  logic                                mem_req_ready,
    output logic                                mem_req_bits_store,
    output logic [ARCH_LEN-1:0]                 mem_req_bits_address,
    output logic [DMEM_SIZE_BITS-1:0]           mem_req_bits_size,
    output logic [DMEM_DATA_BITS-1:0]           mem_req_bits_data,
    output logic [DMEM_MASK_BITS-1:0]           mem_req_bits_mask,
    output logic [MEM_TAG_BITS-1:0]             mem_req_bits_tag,
    input  logic                                mem_resp_valid,
    output logic                                mem_resp_ready,
    input  logic [MEM_TAG_BITS-1:0]             mem_resp_bits_tag,
    input  logic [DMEM_DATA_BITS-1:0]           mem_resp_bits_data
`ifdef DMEM_SERIALIZER_PERF_EN
    ,
    output logic [31:0]                         perf_grants,
    output logic [31:0]                         perf_conflict_cycles
`endif
);

    localparam int unsigned IF_BITS = $clog2(MAX_INFLIGHT + 1);

    typedef struct packed {
        logic                      store;
        logic [ARCH_LEN-1:0]       address;
        logic [DMEM_SIZE_BITS-1:0] size;
        logic [DMEM_DATA_BITS-1:0] data;
        logic [DMEM_MASK_BITS-1:0] mask;
        logic [MEM_TAG_BITS-1:0]   tag;
    } req_t;

    req_t                 oreg;
    logic                 oreg_valid;
    logic [LANE_BITS-1:0] rr_ptr;
    logic [NUM_LANES-1:0] win_grant;
    logic [LANE_BITS-1:0] win_idx;
    logic                 win_any;
    logic [IF_BITS-1:0]   inflight;
    logic                 can_issue;
    logic                 lane_fire;
    logic                 mem_fire;
    logic                 resp_fire;
    logic                 resp_dec;
    logic [LANE_BITS-1:0] resp_lane;

    logic [NUM_LANES-1:0]                     rbuf_valid;
    logic [NUM_LANES-1:0][DMEM_TAG_BITS-1:0]  rbuf_tag;
    logic [NUM_LANES-1:0][DMEM_DATA_BITS-1:0] rbuf_data;

    cyclotron_rr_arbiter #(
        .NUM_LANES (NUM_LANES)
    ) u_arb (
        .req   (lane_req_valid),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign can_issue      = (!oreg_valid || mem_req_ready) && (inflight < IF_BITS'(MAX_INFLIGHT));
    assign lane_req_ready = can_issue ? win_grant : '0;
    assign lane_fire      = can_issue && win_any;
    assign mem_fire       = oreg_valid && mem_req_ready;

    assign mem_req_valid        = oreg_valid;
    assign mem_req_bits_store   = oreg.store;
    assign mem_req_bits_address = oreg.address;
    assign mem_req_bits_size    = oreg.size;
    assign mem_req_bits_data    = oreg.data;
    assign mem_req_bits_mask    = oreg.mask;
    assign mem_req_bits_tag     = oreg.tag;

    // Output stage: load the winner on lane fire, drop once drained with nothing new behind it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oreg_valid <= 1'b0;
            oreg       <= '0;
            rr_ptr     <= '0;
        end else if (lane_fire) begin
            oreg_valid   <= 1'b1;
            oreg.store   <= lane_req_bits_store[win_idx];
            oreg.address <= lane_req_bits_address[win_idx*ARCH_LEN +: ARCH_LEN];
            oreg.size    <= lane_req_bits_size[win_idx*DMEM_SIZE_BITS +: DMEM_SIZE_BITS];
            oreg.data    <= lane_req_bits_data[win_idx*DMEM_DATA_BITS +: DMEM_DATA_BITS];
            oreg.mask    <= lane_req_bits_mask[win_idx*DMEM_MASK_BITS +: DMEM_MASK_BITS];
            oreg.tag     <= {win_idx, lane_req_bits_tag[win_idx*DMEM_TAG_BITS +: DMEM_TAG_BITS]};
            rr_ptr       <= win_idx + LANE_BITS'(1);
        end else if (mem_fire) begin
            oreg_valid <= 1'b0;
        end
    end

    assign resp_lane      = mem_resp_bits_tag[MEM_TAG_BITS-1 -: LANE_BITS];
    assign mem_resp_ready = !rbuf_valid[resp_lane] || lane_resp_ready[resp_lane];
    assign resp_fire      = mem_resp_valid && mem_resp_ready;
    // A stray response with nothing outstanding must not wrap the counter
    assign resp_dec       = resp_fire && (inflight != '0);

    // Outstanding-request counter: issue adds one, response removes one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({lane_fire, resp_dec})
                2'b10:   inflight <= inflight + IF_BITS'(1);
                2'b01:   inflight <= inflight - IF_BITS'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assert property (@(posedge clock) disable iff (reset) !(resp_fire && inflight == '0))
        else $error("mem response with no request outstanding");

    // Per-lane holding register: refill wins over drain in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rbuf_valid <= '0;
            rbuf_tag   <= '0;
            rbuf_data  <= '0;
        end else begin
            for (int unsigned g = 0; g < NUM_LANES; g++) begin
                if (resp_fire && resp_lane == LANE_BITS'(g)) begin
                    rbuf_valid[g] <= 1'b1;
                    rbuf_tag[g]   <= mem_resp_bits_tag[DMEM_TAG_BITS-1:0];
                    rbuf_data[g]  <= mem_resp_bits_data;
                end else if (rbuf_valid[g] && lane_resp_ready[g]) begin
                    rbuf_valid[g] <= 1'b0;
                end
            end
        end
    end

    assign lane_resp_valid     = rbuf_valid;
    assign lane_resp_bits_tag  = rbuf_tag;
    assign lane_resp_bits_data = rbuf_data;

`ifdef DMEM_SERIALIZER_PERF_EN
    logic multi_valid;
    assign multi_valid = |(lane_req_valid & (lane_req_valid - NUM_LANES'(1)));

    // Count grants and cycles where some lane had to wait
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_grants          <= '0;
            perf_conflict_cycles <= '0;
        end else begin
            if (lane_fire) begin
                perf_grants <= perf_grants + 32'd1;
            end
            if (multi_valid || (|lane_req_valid && !can_issue)) begin
                perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cyclotron_dmem_serializer.sv
// Directed self-checking bench for cyclotron_dmem_serializer (default build).
module tb_cyclotron_dmem_serializer;

    localparam int unsigned NL = 16;
    localparam int unsigned AL = 32;
    localparam int unsigned DB = 32;
    localparam int unsigned TB = 32;
    localparam int unsigned SB = 2;
    localparam int unsigned MB = 4;
    localparam int unsigned MT = 36;

    logic               clock;
    logic               reset;
    logic [NL-1:0]      lane_req_valid;
    logic [NL-1:0]      lane_req_ready;
    logic [NL-1:0]      lane_req_bits_store;
    logic [NL*TB-1:0]   lane_req_bits_tag;
    logic [NL*AL-1:0]   lane_req_bits_address;
    logic [NL*SB-1:0]   lane_req_bits_size;
    logic [NL*DB-1:0]   lane_req_bits_data;
    logic [NL*MB-1:0]   lane_req_bits_mask;
    logic [NL-1:0]      lane_resp_valid;
    logic [NL-1:0]      lane_resp_ready;
    logic [NL*TB-1:0]   lane_resp_bits_tag;
    logic [NL*DB-1:0]   lane_resp_bits_data;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic               mem_req_bits_store;
    logic [AL-1:0]      mem_req_bits_address;
    logic [SB-1:0]      mem_req_bits_size;
    logic [DB-1:0]      mem_req_bits_data;
    logic [MB-1:0]      mem_req_bits_mask;
    logic [MT-1:0]      mem_req_bits_tag;
    logic               mem_resp_valid;
    logic               mem_resp_ready;
    logic [MT-1:0]      mem_resp_bits_tag;
    logic [DB-1:0]      mem_resp_bits_data;

    // Second instance with a tight in-flight limit; shares lane-side stimulus
    logic [NL-1:0]      l_lane_req_ready;
    logic [NL-1:0]      l_lane_resp_valid;
    logic [NL*TB-1:0]   l_lane_resp_bits_tag;
    logic [NL*DB-1:0]   l_lane_resp_bits_data;
    logic               l_mem_req_valid;
    logic               l_mem_req_bits_store;
    logic [AL-1:0]      l_mem_req_bits_address;
    logic [SB-1:0]      l_mem_req_bits_size;
    logic [DB-1:0]      l_mem_req_bits_data;
    logic [MB-1:0]      l_mem_req_bits_mask;
    logic [MT-1:0]      l_mem_req_bits_tag;
    logic               l_mem_resp_valid;
    logic               l_mem_resp_ready;

    int unsigned n_checks;
    int unsigned n_fail;

    cyclotron_dmem_serializer #(
        .ARCH_LEN       (AL),
        .NUM_LANES      (NL),
        .DMEM_DATA_BITS (DB),
        .DMEM_TAG_BITS  (TB),
        .MAX_INFLIGHT   (16)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .lane_req_valid        (lane_req_valid),
        .lane_req_ready        (lane_req_ready),
        .lane_req_bits_store   (lane_req_bits_store),
        .lane_req_bits_tag     (lane_req_bits_tag),
        .lane_req_bits_address (lane_req_bits_address),
        .lane_req_bits_size    (lane_req_bits_size),
        .lane_req_bits_data    (lane_req_bits_data),
        .lane_req_bits_mask    (lane_req_bits_mask),
        .lane_resp_valid       (lane_resp_valid),
        .lane_resp_ready       (lane_resp_ready),
        .lane_resp_bits_tag    (lane_resp_bits_tag),
        .lane_resp_bits_data   (lane_resp_bits_data),
        .mem_req_valid         (mem_req_valid),
        .mem_req_ready         (mem_req_ready),
        .mem_req_bits_store    (mem_req_bits_store),
        .mem_req_bits_address  (mem_req_bits_address),
        .mem_req_bits_size     (mem_req_bits_size),
        .mem_req_bits_data     (mem_req_bits_data),
        .mem_req_bits_mask     (mem_req_bits_mask),
        .mem_req_bits_tag      (mem_req_bits_tag),
        .mem_resp_valid        (mem_resp_valid),
        .mem_resp_ready        (mem_resp_ready),
        .mem_resp_bits_tag     (mem_resp_bits_tag),
        .mem_resp_bits_data    (mem_resp_bits_data)
    );

    cyclotron_dmem_serializer #(
        .ARCH_LEN       (AL),
        .NUM_LANES      (NL),
        .DMEM_DATA_BITS (DB),
        .DMEM_TAG_BITS  (TB),
        .MAX_INFLIGHT   (2)
    ) dut_lim (
        .clock                 (clock),
        .reset                 (reset),
        .lane_req_valid        (lane_req_valid),
        .lane_req_ready        (l_lane_req_ready),
        .lane_req_bits_store   (lane_req_bits_store),
        .lane_req_bits_tag     (lane_req_bits_tag),
        .lane_req_bits_address (lane_req_bits_address),
        .lane_req_bits_size    (lane_req_bits_size),
        .lane_req_bits_data    (lane_req_bits_data),
        .lane_req_bits_mask    (lane_req_bits_mask),
        .lane_resp_valid       (l_lane_resp_valid),
        .lane_resp_ready       (lane_resp_ready),
        .lane_resp_bits_tag    (l_lane_resp_bits_tag),
        .lane_resp_bits_data   (l_lane_resp_bits_data),
        .mem_req_valid         (l_mem_req_valid),
        .mem_req_ready         (mem_req_ready),
        .mem_req_bits_store    (l_mem_req_bits_store),
        .mem_req_bits_address  (l_mem_req_bits_address),
        .mem_req_bits_size     (l_mem_req_bits_size),
        .mem_req_bits_data     (l_mem_req_bits_data),
        .mem_req_bits_mask     (l_mem_req_bits_mask),
        .mem_req_bits_tag      (l_mem_req_bits_tag),
        .mem_resp_valid        (l_mem_resp_valid),
        .mem_resp_ready        (l_mem_resp_ready),
        .mem_resp_bits_tag     (mem_resp_bits_tag),
        .mem_resp_bits_data    (mem_resp_bits_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        lane_req_valid        = '0;
        lane_req_bits_store   = '0;
        lane_req_bits_tag     = '0;
        lane_req_bits_address = '0;
        lane_req_bits_size    = '0;
        lane_req_bits_data    = '0;
        lane_req_bits_mask    = '0;
        lane_resp_ready       = '1;
        mem_req_ready         = 1'b1;
        mem_resp_valid        = 1'b0;
        mem_resp_bits_tag     = '0;
        mem_resp_bits_data    = '0;
        l_mem_resp_valid      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [MT-1:0] exp_tag;
        int unsigned   exp_lane;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle_inputs();
        #2;
        check("reset_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("reset_lane_resp_valid", 64'(lane_resp_valid), 64'd0);
        check("reset_mem_req_tag", 64'(mem_req_bits_tag), 64'd0);
        tick();
        reset = 1'b0;

        // Single load from lane 3
        do_reset();
        lane_req_valid                  = NL'(1) << 3;
        lane_req_bits_tag[3*TB +: TB]   = 32'h55;
        lane_req_bits_address[3*AL +: AL] = 32'h1000;
        #1;
        check("t1_lane_ready", 64'(lane_req_ready & lane_req_valid), 64'h8);
        tick();
        lane_req_valid = '0;
        check("t1_mem_valid", 64'(mem_req_valid), 64'd1);
        check("t1_mem_tag", 64'(mem_req_bits_tag), 64'h3_0000_0055);
        check("t1_mem_addr", 64'(mem_req_bits_address), 64'h1000);
        check("t1_mem_store", 64'(mem_req_bits_store), 64'd0);
        tick();
        check("t1_mem_drained", 64'(mem_req_valid), 64'd0);
        mem_resp_valid     = 1'b1;
        mem_resp_bits_tag  = 36'h3_0000_0055;
        mem_resp_bits_data = 32'hDEADBEEF;
        #1;
        check("t1_mem_resp_ready", 64'(mem_resp_ready), 64'd1);
        tick();
        mem_resp_valid = 1'b0;
        check("t1_resp_valid", 64'(lane_resp_valid), 64'h8);
        check("t1_resp_tag", 64'(lane_resp_bits_tag[3*TB +: TB]), 64'h55);
        check("t1_resp_data", 64'(lane_resp_bits_data[3*DB +: DB]), 64'hDEADBEEF);
        tick();
        check("t1_resp_cleared", 64'(lane_resp_valid), 64'd0);

        // All lanes valid: grants 0..15 in order, then in-flight full
        do_reset();
        lane_req_valid = '1;
        for (int g = 0; g < 16; g++) begin
            lane_req_bits_tag[g*TB +: TB] = 32'h100 + 32'(g);
        end
        for (int k = 0; k < 16; k++) begin
            #1;
            check("t2_ready_onehot", 64'(lane_req_ready), 64'(NL'(1) << k));
            tick();
            exp_tag = {4'(k), 32'h100 + 32'(k)};
            check("t2_mem_valid", 64'(mem_req_valid), 64'd1);
            check("t2_mem_tag", 64'(mem_req_bits_tag), 64'(exp_tag));
        end
        #1;
        check("t2_full_ready", 64'(lane_req_ready), 64'd0);

        // Fairness between lanes 2 and 5 with responses echoed back
        do_reset();
        lane_req_valid                = (NL'(1) << 2) | (NL'(1) << 5);
        lane_req_bits_tag[2*TB +: TB] = 32'h22;
        lane_req_bits_tag[5*TB +: TB] = 32'h55;
        for (int i = 0; i < 6; i++) begin
            exp_lane = (i % 2 == 0) ? 2 : 5;
            #1;
            check("t3_ready", 64'(lane_req_ready & lane_req_valid), 64'(NL'(1) << exp_lane));
            tick();
            check("t3_mem_lane", 64'(mem_req_bits_tag[MT-1 -: 4]), 64'(exp_lane));
            mem_resp_valid    = mem_req_valid;
            mem_resp_bits_tag = mem_req_bits_tag;
        end
        lane_req_valid = '0;
        tick();
        mem_resp_valid = 1'b0;

        // Memory backpressure for four cycles
        do_reset();
        lane_req_valid                    = NL'(1) << 4;
        lane_req_bits_tag[4*TB +: TB]     = 32'hA4;
        lane_req_bits_address[4*AL +: AL] = 32'h4000;
        lane_req_bits_tag[6*TB +: TB]     = 32'hA6;
        tick();
        mem_req_ready  = 1'b0;
        lane_req_valid = NL'(1) << 6;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t4_ready_low", 64'(lane_req_ready), 64'd0);
            check("t4_hold_valid", 64'(mem_req_valid), 64'd1);
            check("t4_hold_tag", 64'(mem_req_bits_tag), 64'h4_0000_00A4);
            check("t4_hold_addr", 64'(mem_req_bits_address), 64'h4000);
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        check("t4_resume_ready", 64'(lane_req_ready), 64'(NL'(1) << 6));
        tick();
        lane_req_valid = '0;
        check("t4_next_valid", 64'(mem_req_valid), 64'd1);
        check("t4_next_tag", 64'(mem_req_bits_tag), 64'h6_0000_00A6);
        tick();
        check("t4_drained", 64'(mem_req_valid), 64'd0);

        // In-flight limit of two on the second instance
        do_reset();
        lane_req_valid                = NL'(7);
        lane_req_bits_tag[0*TB +: TB] = 32'hC0;
        #1;
        check("t5_grant0", 64'(l_lane_req_ready & lane_req_valid), 64'h1);
        tick();
        check("t5_grant1", 64'(l_lane_req_ready & lane_req_valid), 64'h2);
        tick();
        check("t5_limit_ready", 64'(l_lane_req_ready), 64'd0);
        check("t5_mem_lane1", 64'(l_mem_req_bits_tag[MT-1 -: 4]), 64'd1);
        tick();
        check("t5_still_limited", 64'(l_lane_req_ready), 64'd0);
        check("t5_oreg_drained", 64'(l_mem_req_valid), 64'd0);
        l_mem_resp_valid  = 1'b1;
        mem_resp_bits_tag = 36'h0_0000_00C0;
        #1;
        check("t5_resp_ready", 64'(l_mem_resp_ready), 64'd1);
        check("t5_ready_before_ret", 64'(l_lane_req_ready), 64'd0);
        tick();
        l_mem_resp_valid = 1'b0;
        #1;
        check("t5_one_more", 64'(l_lane_req_ready & lane_req_valid), 64'h4);
        check("t5_lane0_resp", 64'(l_lane_resp_valid[0]), 64'd1);
        tick();
        check("t5_limit_again", 64'(l_lane_req_ready), 64'd0);
        check("t5_mem_lane2", 64'(l_mem_req_bits_tag[MT-1 -: 4]), 64'd2);
        lane_req_valid = '0;

        // Response routing with a stalled lane, then async reset mid-stream
        do_reset();
        lane_resp_ready    = ~(NL'(1) << 7);
        lane_req_valid     = (NL'(1) << 1) | (NL'(1) << 7);
        tick();
        check("t6_grant_a", 64'(mem_req_bits_tag[MT-1 -: 4]), 64'd1);
        tick();
        check("t6_grant_b", 64'(mem_req_bits_tag[MT-1 -: 4]), 64'd7);
        tick();
        check("t6_grant_c", 64'(mem_req_bits_tag[MT-1 -: 4]), 64'd1);
        lane_req_valid = '0;
        tick();
        mem_resp_valid     = 1'b1;
        mem_resp_bits_tag  = 36'h7_0000_0070;
        mem_resp_bits_data = 32'h7777_0001;
        #1;
        check("t6_r1_ready", 64'(mem_resp_ready), 64'd1);
        tick();
        mem_resp_bits_tag  = 36'h7_0000_0071;
        mem_resp_bits_data = 32'h7777_0002;
        #1;
        check("t6_r2_held", 64'(mem_resp_ready), 64'd0);
        check("t6_l7_data", 64'(lane_resp_bits_data[7*DB +: DB]), 64'h7777_0001);
        tick();
        mem_resp_bits_tag  = 36'h1_0000_0010;
        mem_resp_bits_data = 32'h1111_0001;
        #1;
        check("t6_l1_ready", 64'(mem_resp_ready), 64'd1);
        tick();
        mem_resp_valid = 1'b0;
        check("t6_l1_valid", 64'(lane_resp_valid[1]), 64'd1);
        check("t6_l1_tag", 64'(lane_resp_bits_tag[1*TB +: TB]), 64'h10);
        check("t6_l1_data", 64'(lane_resp_bits_data[1*DB +: DB]), 64'h1111_0001);
        check("t6_l7_stable", 64'(lane_resp_bits_data[7*DB +: DB]), 64'h7777_0001);
        check("t6_l7_valid", 64'(lane_resp_valid[7]), 64'd1);
        lane_req_valid = NL'(1) << 3;
        tick();
        lane_req_valid = '0;
        check("t6_pre_reset_req", 64'(mem_req_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_mem_valid", 64'(mem_req_valid), 64'd0);
        check("t6_rst_resp_valid", 64'(lane_resp_valid), 64'd0);
        check("t6_rst_inflight", 64'(dut.inflight), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
